// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and hex-to-segment decode for the scanned display
// Contents:
//   SEG_OFF     all segments dark in active-low form
//   PWM_W       width of the brightness code and of the PWM phase slice
//   hex_to_seg  4-bit hex digit -> active-low {dp,g,f,e,d,c,b,a}, dp dark
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam int         PWM_W   = 4;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
        logic [7:0] pattern;
        case (hex)
            4'h0:    pattern = 8'hC0;
            4'h1:    pattern = 8'hF9;
            4'h2:    pattern = 8'hA4;
            4'h3:    pattern = 8'hB0;
            4'h4:    pattern = 8'h99;
            4'h5:    pattern = 8'h92;
            4'h6:    pattern = 8'h82;
            4'h7:    pattern = 8'hF8;
            4'h8:    pattern = 8'h80;
            4'h9:    pattern = 8'h98;
            4'hA:    pattern = 8'h88;
            4'hB:    pattern = 8'h83;
            4'hC:    pattern = 8'hC6;
            4'hD:    pattern = 8'hA1;
            4'hE:    pattern = 8'h86;
            default: pattern = 8'h8E;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// rtl/seg_scan_display_if.sv - display-data bus between the CPU side and the scanner
// Signals:
//   num        4*N_DIGITS hex value, digit 0 in the low nibble
//   dp         per-digit decimal point, 1 = lit
//   blank_lz   1 = blank leading zero digits
//   load       1-cycle strobe capturing num/dp/blank_lz
//   brightness 0 = 1/16 duty .. 15 = full duty
//   an         digit enables to the board
//   seg        {dp,g..a} to the board
//   pending    a loaded value is waiting for the next frame
//   frame_done 1-cycle pulse at the end of the last digit slot
// Modports: master drives the data/strobe side, slave is the scanner.
interface seg_scan_display_if #(
    parameter int N_DIGITS = 8
);
    logic [4*N_DIGITS-1:0] num;
    logic [N_DIGITS-1:0]   dp;
    logic                  blank_lz;
    logic                  load;
    logic [3:0]            brightness;
    logic [N_DIGITS-1:0]   an;
    logic [7:0]            seg;
    logic                  pending;
    logic                  frame_done;

    modport master (
        output num, dp, blank_lz, load, brightness,
        input  an, seg, pending, frame_done
    );

    modport slave (
        input  num, dp, blank_lz, load, brightness,
        output an, seg, pending, frame_done
    );
endinterface

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - combinational digit decode with blanking and decimal point merge
// Ports:
//   i_hex    digit value
//   i_dp     1 = decimal point lit
//   i_blank  1 = segments a..g dark (dp still follows i_dp)
//   o_seg    active-low {dp,g..a}
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] i_hex,
    input  logic       i_dp,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    logic [7:0] w_pattern;
    logic [7:0] w_body;

    assign w_pattern = hex_to_seg(i_hex);
    assign w_body    = i_blank ? SEG_OFF : w_pattern;
    assign o_seg     = w_body & (i_dp ? 8'h7F : 8'hFF);

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - time-multiplexed N-digit 7-segment scanner with PWM dimming
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  seg_scan_display_if.slave: num/dp/blank_lz/load/brightness in,
//        an/seg/pending/frame_done out (all outputs registered)
// Parameters: N_DIGITS (1..16), SCAN_DIV_LOG2 (>= 4, clocks per slot = 2**SCAN_DIV_LOG2),
//   ACTIVE_LOW (1: an/seg active-low, 0: both inverted).
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int N_DIGITS      = 8,
    parameter int SCAN_DIV_LOG2 = 16,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input logic              clk,
    input logic              rst,
    seg_scan_display_if.slave bus
);

    localparam int               POS_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_DIGITS - 1);

    logic [SCAN_DIV_LOG2-1:0] r_tick;
    logic [POS_W-1:0]         r_pos;

    logic [4*N_DIGITS-1:0]    r_sh_num;
    logic [N_DIGITS-1:0]      r_sh_dp;
    logic                     r_sh_blz;
    logic                     r_pending;

    logic [4*N_DIGITS-1:0]    r_act_num;
    logic [N_DIGITS-1:0]      r_act_dp;
    logic                     r_act_blz;

    logic [N_DIGITS-1:0]      r_an;
    logic [7:0]               r_seg;
    logic                     r_frame_done;

    logic                     w_slot_end;
    logic                     w_wrap;
    logic [N_DIGITS-1:0]      w_blank;
    logic [3:0]               w_digit;
    logic                     w_dp;
    logic                     w_blank_cur;
    logic [7:0]               w_seg_al;
    logic [PWM_W-1:0]         w_phase;
    logic                     w_lit;
    logic [N_DIGITS-1:0]      w_an_on;

    assign w_slot_end = &r_tick;
    assign w_wrap     = w_slot_end && (r_pos == LAST_POS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick <= '0;
            r_pos  <= '0;
        end else begin
            r_tick <= r_tick + 1'b1;
            if (w_slot_end) begin
                r_pos <= w_wrap ? '0 : r_pos + 1'b1;
            end
        end
    end

    // The active copy only changes on the wrap edge, which is also the edge
    // that moves pos back to 0, so a frame is always drawn from one load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_num  <= '0;
            r_sh_dp   <= '0;
            r_sh_blz  <= 1'b0;
            r_pending <= 1'b0;
            r_act_num <= '0;
            r_act_dp  <= '0;
            r_act_blz <= 1'b0;
        end else if (bus.load) begin
            r_sh_num <= bus.num;
            r_sh_dp  <= bus.dp;
            r_sh_blz <= bus.blank_lz;
            if (w_wrap) begin
                // Strobe on the wrap cycle skips the shadow stage entirely.
                r_act_num <= bus.num;
                r_act_dp  <= bus.dp;
                r_act_blz <= bus.blank_lz;
                r_pending <= 1'b0;
            end else begin
                r_pending <= 1'b1;
            end
        end else if (w_wrap && r_pending) begin
            r_act_num <= r_sh_num;
            r_act_dp  <= r_sh_dp;
            r_act_blz <= r_sh_blz;
            r_pending <= 1'b0;
        end
    end

    // Walk from the most significant digit down; a digit is blanked while
    // every digit at or above it is zero. Digit 0 is always shown.
    always_comb begin
        logic v_run;
        w_blank = '0;
        v_run   = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            v_run      = v_run && (r_act_num[4*i +: 4] == 4'h0);
            w_blank[i] = r_act_blz && v_run && (i != 0);
        end
    end

    assign w_digit     = r_act_num[4*r_pos +: 4];
    assign w_dp        = r_act_dp[r_pos];
    assign w_blank_cur = w_blank[r_pos];

    seg_decoder u_decoder (
        .i_hex   (w_digit),
        .i_dp    (w_dp),
        .i_blank (w_blank_cur),
        .o_seg   (w_seg_al)
    );

    // The top PWM_W bits of the slot counter split each slot into 16 phases.
    assign w_phase = r_tick[SCAN_DIV_LOG2-1 -: PWM_W];
    assign w_lit   = (w_phase <= bus.brightness);

    always_comb begin
        w_an_on = '0;
        if (w_lit) begin
            w_an_on[r_pos] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an         <= {N_DIGITS{ACTIVE_LOW}};
            r_seg        <= ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= ACTIVE_LOW ? ~w_an_on : w_an_on;
            r_seg        <= ACTIVE_LOW ? w_seg_al : ~w_seg_al;
            r_frame_done <= w_wrap;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.pending    = r_pending;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - directed self-checking bench for seg_scan_display
module tb_seg_scan_display;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    seg_scan_display_if #(.N_DIGITS(4)) bus ();

    seg_scan_display #(
        .N_DIGITS      (4),
        .SCAN_DIV_LOG2 (4),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Returns at the first falling edge where frame_done is high (possibly the current one).
    task automatic sync_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Captures slot-start seg/an of digits 0..3 for one whole frame; ends on the next frame_done.
    task automatic read_frame(output logic [31:0] segs, output logic [15:0] ans, output bit ok);
        sync_frame(ok);
        segs = '0;
        ans  = '0;
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            segs[8*d +: 8] = bus.seg;
            ans[4*d +: 4]  = bus.an;
            repeat (15) @(negedge clk);
        end
    endtask

    task automatic load_value(input logic [15:0] n, input logic [3:0] d, input logic b);
        bus.num      = n;
        bus.dp       = d;
        bus.blank_lz = b;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    task automatic test_reset;
        int fd_extra;
        logic fd64, fd128;
        rst            = 1'b1;
        bus.num        = '0;
        bus.dp         = '0;
        bus.blank_lz   = 1'b0;
        bus.load       = 1'b0;
        bus.brightness = 4'd15;
        repeat (3) @(negedge clk);
        checks++; if (bus.an !== 4'hF) begin errors++; $display("FAIL reset_an: got %h expected %h", bus.an, 4'hF); end
        checks++; if (bus.seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h expected %h", bus.seg, 8'hFF); end
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", bus.pending); end
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
        rst      = 1'b0;
        fd_extra = 0;
        fd64     = 1'b0;
        fd128    = 1'b0;
        for (int k = 1; k <= 130; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++; if (bus.an !== 4'hE) begin errors++; $display("FAIL scan_an_d0: got %h expected %h", bus.an, 4'hE); end
                checks++; if (bus.seg !== 8'hC0) begin errors++; $display("FAIL scan_seg_d0: got %h expected %h", bus.seg, 8'hC0); end
            end
            if (k == 16) begin
                checks++; if (bus.an !== 4'hE) begin errors++; $display("FAIL scan_an_d0_end: got %h expected %h", bus.an, 4'hE); end
            end
            if (k == 17) begin
                checks++; if (bus.an !== 4'hD) begin errors++; $display("FAIL scan_an_d1: got %h expected %h", bus.an, 4'hD); end
            end
            if (k == 33) begin
                checks++; if (bus.an !== 4'hB) begin errors++; $display("FAIL scan_an_d2: got %h expected %h", bus.an, 4'hB); end
            end
            if (k == 49) begin
                checks++; if (bus.an !== 4'h7) begin errors++; $display("FAIL scan_an_d3: got %h expected %h", bus.an, 4'h7); end
            end
            if (k == 64) fd64 = bus.frame_done;
            else if (k == 128) fd128 = bus.frame_done;
            else if (bus.frame_done !== 1'b0) fd_extra++;
        end
        checks++; if (fd64 !== 1'b1) begin errors++; $display("FAIL frame_done_64: got %b expected 1", fd64); end
        checks++; if (fd128 !== 1'b1) begin errors++; $display("FAIL frame_done_128: got %b expected 1", fd128); end
        checks++; if (fd_extra != 0) begin errors++; $display("FAIL frame_done_extra: got %0d expected 0", fd_extra); end
    endtask

    task automatic test_load;
        int bad;
        bit found, ok;
        logic [31:0] segs;
        logic [15:0] ans;
        repeat (5) @(negedge clk);
        load_value(16'h12AF, 4'b0100, 1'b0);
        checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL load_pending_set: got %b expected 1", bus.pending); end
        bad   = 0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.frame_done === 1'b1) begin
                found = 1'b1;
                break;
            end
            if (bus.seg !== 8'hC0) bad++;
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL load_wrap_seen: got 0 expected 1"); end
        checks++; if (bad != 0) begin errors++; $display("FAIL load_old_held: got %0d changed cycles expected 0", bad); end
        read_frame(segs, ans, ok);
        checks++; if (!ok) begin errors++; $display("FAIL load_frame_sync: got timeout expected frame_done"); end
        checks++; if (segs !== 32'hF9_24_88_8E) begin errors++; $display("FAIL load_segs: got %h expected %h", segs, 32'hF9_24_88_8E); end
        checks++; if (ans !== 16'h7BDE) begin errors++; $display("FAIL load_ans: got %h expected %h", ans, 16'h7BDE); end
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL load_pending_clear: got %b expected 0", bus.pending); end
    endtask

    task automatic test_blank;
        bit ok;
        logic [31:0] segs;
        logic [15:0] ans;
        load_value(16'h0030, 4'b0000, 1'b1);
        read_frame(segs, ans, ok);
        checks++; if (!ok || segs !== 32'hFF_FF_B0_C0) begin errors++; $display("FAIL blank_0030: got %h expected %h", segs, 32'hFF_FF_B0_C0); end
        load_value(16'h0000, 4'b0000, 1'b1);
        read_frame(segs, ans, ok);
        checks++; if (!ok || segs !== 32'hFF_FF_FF_C0) begin errors++; $display("FAIL blank_0000: got %h expected %h", segs, 32'hFF_FF_FF_C0); end
        checks++; if (ans !== 16'h7BDE) begin errors++; $display("FAIL blank_ans: got %h expected %h", ans, 16'h7BDE); end
    endtask

    task automatic test_back_to_back;
        int seen_one;
        bit ok, found;
        logic [31:0] segs;
        logic [15:0] ans;
        sync_frame(ok);
        load_value(16'h1111, 4'b0000, 1'b0);
        repeat (3) @(negedge clk);
        load_value(16'h2222, 4'b0000, 1'b0);
        checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL b2b_pending: got %b expected 1", bus.pending); end
        seen_one = 0;
        found    = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.frame_done === 1'b1) begin
                found = 1'b1;
                break;
            end
            if (bus.seg === 8'hF9) seen_one++;
            @(negedge clk);
        end
        checks++; if (!found || seen_one != 0) begin errors++; $display("FAIL b2b_first_hidden: got %0d cycles of 1 expected 0", seen_one); end
        read_frame(segs, ans, ok);
        checks++; if (!ok || segs !== 32'hA4_A4_A4_A4) begin errors++; $display("FAIL b2b_last_wins: got %h expected %h", segs, 32'hA4_A4_A4_A4); end
    endtask

    task automatic test_load_on_wrap;
        bit ok;
        logic [31:0] segs;
        logic [15:0] ans;
        sync_frame(ok);
        repeat (63) @(negedge clk);
        load_value(16'h5678, 4'b0000, 1'b0);
        checks++; if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL wrap_aligned: got %b expected 1", bus.frame_done); end
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL wrap_pending: got %b expected 0", bus.pending); end
        read_frame(segs, ans, ok);
        checks++; if (!ok || segs !== 32'h92_82_F8_80) begin errors++; $display("FAIL wrap_segs: got %h expected %h", segs, 32'h92_82_F8_80); end
    endtask

    task automatic test_pwm;
        int cnt3[4];
        int cnt0[4];
        int multi;
        bit ok;
        sync_frame(ok);
        bus.brightness = 4'd3;
        multi = 0;
        for (int d = 0; d < 4; d++) begin cnt3[d] = 0; cnt0[d] = 0; end
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) if (bus.an[d] === 1'b0) cnt3[d]++;
            if ($countones(~bus.an) > 1) multi++;
        end
        bus.brightness = 4'd0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) if (bus.an[d] === 1'b0) cnt0[d]++;
            if ($countones(~bus.an) > 1) multi++;
        end
        for (int d = 0; d < 4; d++) begin
            checks++; if (cnt3[d] != 4) begin errors++; $display("FAIL pwm3_digit%0d: got %0d expected 4", d, cnt3[d]); end
            checks++; if (cnt0[d] != 1) begin errors++; $display("FAIL pwm0_digit%0d: got %0d expected 1", d, cnt0[d]); end
        end
        checks++; if (multi != 0) begin errors++; $display("FAIL pwm_one_hot: got %0d cycles expected 0", multi); end
        bus.brightness = 4'd15;
    endtask

    task automatic test_reset_mid;
        bit ok;
        logic [31:0] segs;
        logic [15:0] ans;
        repeat (10) @(negedge clk);
        load_value(16'h9999, 4'b1111, 1'b0);
        checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL rstmid_pending_before: got %b expected 1", bus.pending); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.an !== 4'hF) begin errors++; $display("FAIL rstmid_an: got %h expected %h", bus.an, 4'hF); end
        checks++; if (bus.seg !== 8'hFF) begin errors++; $display("FAIL rstmid_seg: got %h expected %h", bus.seg, 8'hFF); end
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL rstmid_pending: got %b expected 0", bus.pending); end
        @(negedge clk);
        rst = 1'b0;
        read_frame(segs, ans, ok);
        checks++; if (!ok || segs !== 32'hC0_C0_C0_C0) begin errors++; $display("FAIL rstmid_discard: got %h expected %h", segs, 32'hC0_C0_C0_C0); end
        checks++; if (ans !== 16'h7BDE) begin errors++; $display("FAIL rstmid_ans: got %h expected %h", ans, 16'h7BDE); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_blank();
        test_back_to_back();
        test_load_on_wrap();
        test_pwm();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
